// File: rtl/apb_i2c_pkg.sv
// apb_i2c_pkg: register offsets, reset values, command bits and FSM states for the APB I2C register bank
package apb_i2c_pkg;
  localparam logic [4:0] PRER_OFS = 5'h00;
  localparam logic [4:0] CTR_OFS = 5'h04;
  localparam logic [4:0] TXR_OFS = 5'h08;
  localparam logic [4:0] CMD_OFS = 5'h0C;
  localparam logic [15:0] PRER_RST = 16'hFFFF;
  localparam int CMD_STA = 7;
  localparam int CMD_STO = 6;
  localparam int CMD_RD = 5;
  localparam int CMD_WR = 4;
  localparam int CMD_ACK = 3;
  localparam int CMD_IACK = 0;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} apb_state_t;
  function automatic logic [7:0] cmd_bits(input logic [7:0] d);
    cmd_bits = '0;
    cmd_bits[CMD_STA] = d[CMD_STA];
    cmd_bits[CMD_STO] = d[CMD_STO];
    cmd_bits[CMD_RD] = d[CMD_RD];
    cmd_bits[CMD_WR] = d[CMD_WR];
    cmd_bits[CMD_ACK] = d[CMD_ACK];
    cmd_bits[CMD_IACK] = d[CMD_IACK];
  endfunction
endpackage

// File: rtl/apb_i2c_regs_if.sv
// apb_i2c_regs_if: APB bus signals between fabric master and the I2C register completer
interface apb_i2c_regs_if;
  logic psel, pen, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;
  modport master (output psel, pen, pwrite, paddr, pwdata, input prdata, pready);
  modport slave (input psel, pen, pwrite, paddr, pwdata, output prdata, pready);
endinterface

// File: rtl/apb_i2c_regs.sv
// apb_i2c_regs: APB completer with programmable wait states exposing the I2C master register bank
module apb_i2c_regs
  import apb_i2c_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  apb_i2c_regs_if.slave apb,
  output logic [15:0] prer,
  output logic [7:0] ctr,
  output logic [7:0] txr,
  output logic [7:0] cmd,
  output logic cmd_stb,
  input  logic [7:0] rxr,
  input  logic [7:0] sr
);
  apb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] addr_q, addr_d;
  logic wr_q, wr_d;
  logic [15:0] wdata_q, wdata_d, prer_q, prer_d;
  logic [31:0] prdata_q, prdata_d, rd_val;
  logic [1:0] ctr_q, ctr_d;
  logic [7:0] txr_q, txr_d, cmd_q, cmd_d;
  logic cmd_stb_q, cmd_stb_d;
  logic unused;
  assign unused = ^{apb.paddr[31:5], apb.paddr[1:0], apb.pwdata[31:16]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wr_d = wr_q;
    wdata_d = wdata_q;
    prdata_d = prdata_q;
    prer_d = prer_q;
    ctr_d = ctr_q;
    txr_d = txr_q;
    cmd_d = '0;
    cmd_stb_d = 1'b0;
    case (state_q)
      IDLE: if (apb.psel && apb.pen) begin
        addr_d = {apb.paddr[4:2], 2'b00};
        wr_d = apb.pwrite;
        wdata_d = apb.pwdata[15:0];
        cnt_d = 4'(WAIT_STATES);
        state_d = WAIT_STATES == 0 ? DONE : WAIT;
      end
      WAIT: if (!apb.psel) state_d = IDLE;
      else begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? DONE : WAIT;
      end
      DONE: begin
        state_d = HOLD;
        if (wr_q) begin
          prer_d = addr_q == PRER_OFS ? wdata_q : prer_q;
          ctr_d = addr_q == CTR_OFS ? wdata_q[7:6] : ctr_q;
          txr_d = addr_q == TXR_OFS ? wdata_q[7:0] : txr_q;
          cmd_stb_d = addr_q == CMD_OFS;
          cmd_d = cmd_stb_d ? cmd_bits(wdata_q[7:0]) : '0;
        end
      end
      default: state_d = apb.pen ? HOLD : IDLE;
    endcase
    // addr_d already holds the bus address on a zero-wait IDLE->DONE hop
    rd_val = addr_d == PRER_OFS ? {16'h0, prer_q} :
             addr_d == CTR_OFS ? {24'h0, ctr_q, 6'h0} :
             addr_d == TXR_OFS ? {24'h0, rxr} :
             addr_d == CMD_OFS ? {24'h0, sr} : '0;
    if (state_d == DONE && !wr_d) prdata_d = rd_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      prdata_q <= '0;
      prer_q <= PRER_RST;
      ctr_q <= '0;
      txr_q <= '0;
      cmd_q <= '0;
      cmd_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      prdata_q <= prdata_d;
      prer_q <= prer_d;
      ctr_q <= ctr_d;
      txr_q <= txr_d;
      cmd_q <= cmd_d;
      cmd_stb_q <= cmd_stb_d;
    end
  end
  assign apb.pready = state_q == DONE;
  assign apb.prdata = prdata_q;
  assign prer = prer_q;
  assign ctr = {ctr_q, 6'h0};
  assign txr = txr_q;
  assign cmd = cmd_q;
  assign cmd_stb = cmd_stb_q;
endmodule

// File: tb/tb_apb_i2c_regs.sv
// tb_apb_i2c_regs: directed APB transfers against the register bank with 1, 0 and 15 wait states
module tb_apb_i2c_regs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rxr = 8'h0, sr = 8'h0;
  logic [15:0] prer, prer0, prer15;
  logic [7:0] ctr, txr, cmd, ctr0, txr0, cmd0, ctr15, txr15, cmd15;
  logic cmd_stb, stb0, stb15;
  logic [31:0] rd;
  logic [7:0] stb_cmd = 8'h0;
  int checks = 0, errors = 0, rdy_cnt = 0, stb_cnt = 0, lat, n_r, n_s;
  always #5 clk = ~clk;
  apb_i2c_regs_if m();
  apb_i2c_regs_if m0();
  apb_i2c_regs_if m15();
  apb_i2c_regs #(.WAIT_STATES(1)) dut (.clk(clk), .rst(rst), .apb(m), .prer(prer), .ctr(ctr), .txr(txr),
    .cmd(cmd), .cmd_stb(cmd_stb), .rxr(rxr), .sr(sr));
  apb_i2c_regs #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .apb(m0), .prer(prer0), .ctr(ctr0), .txr(txr0),
    .cmd(cmd0), .cmd_stb(stb0), .rxr(rxr), .sr(sr));
  apb_i2c_regs #(.WAIT_STATES(15)) dut15 (.clk(clk), .rst(rst), .apb(m15), .prer(prer15), .ctr(ctr15), .txr(txr15),
    .cmd(cmd15), .cmd_stb(stb15), .rxr(rxr), .sr(sr));
  always @(negedge clk) begin
    if (m.pready) rdy_cnt++;
    if (cmd_stb) begin
      stb_cnt++;
      stb_cmd = cmd;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r, output int l);
    m.psel = 1'b1;
    m.pen = 1'b1;
    m.pwrite = w;
    m.paddr = a;
    m.pwdata = d;
    l = 0;
    do begin
      step();
      l++;
    end while (!m.pready && l < 40);
    if (!m.pready) chk("pready_timeout", {31'h0, m.pready}, 32'h1);
    r = m.prdata;
    m.psel = 1'b0;
    m.pen = 1'b0;
    step();
    step();
  endtask
  initial begin
    {m.psel, m.pen, m.pwrite, m.paddr, m.pwdata} = '0;
    {m0.psel, m0.pen, m0.pwrite, m0.paddr, m0.pwdata} = '0;
    {m15.psel, m15.pen, m15.pwrite, m15.paddr, m15.pwdata} = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_pready", {31'h0, m.pready}, 32'h0);
    chk("rst_prdata", m.prdata, 32'h0);
    chk("rst_cmd_stb", {31'h0, cmd_stb}, 32'h0);
    chk("rst_cmd", {24'h0, cmd}, 32'h0);
    chk("rst_prer", {16'h0, prer}, 32'hFFFF);
    chk("rst_ctr", {24'h0, ctr}, 32'h0);
    chk("rst_txr", {24'h0, txr}, 32'h0);
    xfer(1'b1, 32'h00, 32'h0000_1234, rd, lat);
    chk("prer_wr_lat", lat, 32'd2);
    chk("prer_wr", {16'h0, prer}, 32'h1234);
    xfer(1'b0, 32'h00, 32'h0, rd, lat);
    chk("prer_rd_lat", lat, 32'd2);
    chk("prer_rd", rd, 32'h0000_1234);
    xfer(1'b1, 32'h04, 32'hFF, rd, lat);
    chk("ctr_pin", {24'h0, ctr}, 32'hC0);
    xfer(1'b0, 32'h04, 32'h0, rd, lat);
    chk("ctr_rd", rd, 32'hC0);
    xfer(1'b1, 32'h08, 32'h5A, rd, lat);
    chk("txr_wr", {24'h0, txr}, 32'h5A);
    rxr = 8'hA5;
    sr = 8'h81;
    xfer(1'b0, 32'h08, 32'h0, rd, lat);
    chk("rxr_rd", rd, 32'hA5);
    xfer(1'b0, 32'h0C, 32'h0, rd, lat);
    chk("sr_rd", rd, 32'h81);
    chk("txr_kept", {24'h0, txr}, 32'h5A);
    n_r = rdy_cnt;
    n_s = stb_cnt;
    m.psel = 1'b1;
    m.pen = 1'b1;
    m.pwrite = 1'b1;
    m.paddr = 32'h0C;
    m.pwdata = 32'h91;
    repeat (8) step();
    chk("cmd_one_pready", rdy_cnt - n_r, 32'd1);
    chk("cmd_one_stb", stb_cnt - n_s, 32'd1);
    chk("cmd_val", {24'h0, stb_cmd}, 32'h91);
    chk("cmd_cleared", {24'h0, cmd}, 32'h0);
    m.psel = 1'b0;
    m.pen = 1'b0;
    step();
    step();
    xfer(1'b1, 32'h14, 32'hDEAD_BEEF, rd, lat);
    chk("unmapped_lat", lat, 32'd2);
    chk("unmapped_prer", {16'h0, prer}, 32'h1234);
    chk("unmapped_ctr", {24'h0, ctr}, 32'hC0);
    chk("unmapped_txr", {24'h0, txr}, 32'h5A);
    xfer(1'b0, 32'h14, 32'h0, rd, lat);
    chk("unmapped_rd", rd, 32'h0);
    xfer(1'b1, 32'h00, 32'hFFFF_ABCD, rd, lat);
    chk("prer_upper_ignored", {16'h0, prer}, 32'hABCD);
    rxr = 8'h11;
    m.psel = 1'b1;
    m.pen = 1'b1;
    m.pwrite = 1'b0;
    m.paddr = 32'h08;
    step();
    rxr = 8'h22;
    step();
    chk("rxr_late_pready", {31'h0, m.pready}, 32'h1);
    chk("rxr_late_val", m.prdata, 32'h22);
    m.psel = 1'b0;
    m.pen = 1'b0;
    step();
    step();
    n_r = rdy_cnt;
    m.psel = 1'b1;
    m.pen = 1'b1;
    m.pwrite = 1'b1;
    m.paddr = 32'h04;
    m.pwdata = 32'h0;
    step();
    m.psel = 1'b0;
    m.pen = 1'b0;
    repeat (3) step();
    chk("abort_no_pready", rdy_cnt - n_r, 32'd0);
    chk("abort_no_commit", {24'h0, ctr}, 32'hC0);
    m.psel = 1'b1;
    m.pen = 1'b1;
    m.paddr = 32'h00;
    m.pwdata = 32'h4321;
    step();
    rst = 1'b1;
    m.psel = 1'b0;
    m.pen = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_wait_no_pready", rdy_cnt - n_r, 32'd0);
    chk("rst_wait_prer", {16'h0, prer}, 32'hFFFF);
    xfer(1'b1, 32'h00, 32'h0042, rd, lat);
    chk("after_rst_lat", lat, 32'd2);
    chk("after_rst_prer", {16'h0, prer}, 32'h0042);
    m0.psel = 1'b1;
    m0.pen = 1'b1;
    m0.pwrite = 1'b0;
    m0.paddr = 32'h00;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!m0.pready && lat < 40);
    chk("ws0_lat", lat, 32'd1);
    chk("ws0_rd", m0.prdata, 32'hFFFF);
    m0.psel = 1'b0;
    m0.pen = 1'b0;
    step();
    step();
    m15.psel = 1'b1;
    m15.pen = 1'b1;
    m15.pwrite = 1'b1;
    m15.paddr = 32'h14;
    m15.pwdata = 32'hDEAD_BEEF;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!m15.pready && lat < 40);
    chk("ws15_lat", lat, 32'd16);
    m15.psel = 1'b0;
    m15.pen = 1'b0;
    step();
    step();
    chk("ws15_prer", {16'h0, prer15}, 32'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
